xor_stream_decoder: RTL and testbench
=====================================

XOR_STREAM_DECODER -- requirements
Module: xor_stream_decoder

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port key_base, input, 8, shared base key, the same value the encrypting side uses.
REQ-004 SHALL have port key_load, input, 1, one-cycle pulse that loads key_base into the key LFSR and restarts the stream.
REQ-005 SHALL have port cipher_in, input, 8, ciphertext byte.
REQ-006 SHALL have port cipher_valid, input, 1, cipher_in valid.
REQ-007 SHALL have port cipher_ready, output, 1, decoder accepts cipher_in this cycle.
REQ-008 SHALL have port plain_out, output, 8, decrypted byte, registered.
REQ-009 SHALL have port plain_valid, output, 1, plain_out valid.
REQ-010 SHALL have port plain_ready, input, 1, downstream accepts plain_out.
REQ-011 SHALL have port key_cur, output, 8, current LFSR key for debug.
REQ-012 SHALL have port byte_cnt, output, 8, accepted-byte counter (see Configuration).

Function
REQ-013 SHALL implement states IDLE (no key loaded) and RUN; IDLE->RUN on key_load; RUN->RUN on key_load; no path returns to IDLE except reset.
REQ-014 SHALL hold cipher_ready = (state==RUN) & !key_load & (!plain_valid | plain_ready), combinational.
REQ-015 SHALL, on accept (cipher_valid & cipher_ready), register plain_out = cipher_in XOR lfsr and set plain_valid on the next edge (latency 1 cycle).
REQ-016 SHALL advance the LFSR exactly once per accepted byte: lfsr <= {lfsr[6:0], lfsr[4]^lfsr[3]}; no advance otherwise.
REQ-017 SHALL clear plain_valid on plain_ready when no new byte is accepted in the same cycle; accept plus plain_ready in one cycle SHALL sustain 1 byte/cycle.
REQ-018 SHALL hold plain_out and plain_valid stable while plain_valid & !plain_ready.
REQ-019 SHALL, on key_load, load lfsr = key_base (8'h01 if key_base==8'h00, to avoid lock-up), clear plain_valid (the pending byte is discarded), and clear byte_cnt.
REQ-020 SHALL give key_load priority over any simultaneous accept or plain_ready.
REQ-021 SHALL hold key_cur equal to the lfsr register at all times.
REQ-022 SHALL ignore cipher_valid in IDLE, with cipher_ready=0.

Reset
REQ-023 SHALL, on rst_n low, go asynchronously to IDLE, with lfsr=8'h00, plain_out=8'h00, plain_valid=0, byte_cnt=8'h00 and cipher_ready=0.
REQ-024 SHALL, on reset mid-transfer, discard the pending byte; after reset release, decoding resumes only after a new key_load.

Configuration
REQ-025 SHALL, with XSD_BYTE_COUNT_EN defined, increment byte_cnt by 1 per accepted byte, wrapping from 8'hFF to 8'h00.
REQ-026 SHALL, with XSD_BYTE_COUNT_EN undefined, omit the counter logic and keep the byte_cnt port driven constant 8'h00.

Structure
REQ-027 SHALL take LFSR width (8), tap positions (4,3), the zero-key substitute (8'h01) and the state encoding from a shared cipher package also used by the key generator.
REQ-028 SHALL put the LFSR step in one sub-module, lfsr_step (combinational next-state function), shared with the encrypting side.

Verification
REQ-029 SHALL cover: key_base=8'h5A, key_load, then cipher 8'h3C -> plain_out=8'h66 one cycle later, key_cur=8'hB4.
REQ-030 SHALL cover: next cipher 8'hB4 back-to-back with plain_ready=1 -> plain_out=8'h00, key_cur=8'h69, 1 byte/cycle, no bubbles.
REQ-031 SHALL cover: plain_ready=0 for 3 cycles with plain_valid high -> cipher_ready=0, plain_out and key_cur unchanged, no byte lost.
REQ-032 SHALL cover: key_base=8'h00, key_load, cipher 8'hFF -> plain_out=8'hFE, key_cur starts at 8'h01.
REQ-033 SHALL cover: key_load in the same cycle as cipher_valid -> byte not accepted, plain_valid=0 next cycle, LFSR equals the new key_base, byte_cnt=0.
REQ-034 SHALL cover: 256 accepted bytes with XSD_BYTE_COUNT_EN -> byte_cnt wraps to 8'h00; rst_n pulsed mid-stream -> IDLE, cipher_ready=0 until key_load.

Source files
------------

// File: rtl/xor_stream_decoder_pkg.sv
// Shared cipher definitions: LFSR geometry, zero-key substitute and FSM encoding.
// Used by the decoder and the matching key generator on the encrypting side.
package xor_stream_decoder_pkg;

  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned TAP_HI   = 4;
  localparam int unsigned TAP_LO   = 3;
  localparam logic [LFSR_W-1:0] ZERO_KEY_SUB = 8'h01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [LFSR_W-1:0] data;
  } plain_t;

  // An all-zero LFSR would stay zero forever, so it is never seeded with zero.
  function automatic logic [LFSR_W-1:0] key_seed(input logic [LFSR_W-1:0] key);
    return (key == '0) ? ZERO_KEY_SUB : key;
  endfunction

endpackage

// File: rtl/xor_stream_decoder_lfsr_step.sv
// Combinational next-state of the key LFSR (shift left, feedback from the taps).
// Identical instance lives on the encrypting side so both streams stay in lockstep.
module lfsr_step
  import xor_stream_decoder_pkg::*;
(
  input  logic [LFSR_W-1:0] i_lfsr,
  output logic [LFSR_W-1:0] o_lfsr_nxt
);

  logic w_fb;

  assign w_fb       = i_lfsr[TAP_HI] ^ i_lfsr[TAP_LO];
  assign o_lfsr_nxt = {i_lfsr[LFSR_W-2:0], w_fb};

endmodule

// File: rtl/xor_stream_decoder.sv
// XOR stream decoder: ciphertext XOR LFSR keystream, one-deep registered output.
// Optional accepted-byte counter enabled by defining XSD_BYTE_COUNT_EN.
module xor_stream_decoder
  import xor_stream_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] key_base,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] cipher_in,
  input  logic              cipher_valid,
  output logic              cipher_ready,
  output logic [LFSR_W-1:0] plain_out,
  output logic              plain_valid,
  input  logic              plain_ready,
  output logic [LFSR_W-1:0] key_cur,
  output logic [7:0]        byte_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  plain_t            r_plain;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic              w_cipher_ready;
  logic              w_accept;

  lfsr_step u_lfsr_step (
    .i_lfsr     (r_lfsr),
    .o_lfsr_nxt (w_lfsr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Only reset leaves RUN; a key load always (re)enters it.
  always_comb begin
    w_state_nxt = r_state;
    if (key_load) w_state_nxt = ST_RUN;
  end

  always_comb begin
    w_cipher_ready = 1'b0;
    if (r_state == ST_RUN)
      w_cipher_ready = !key_load && (!r_plain.vld || plain_ready);
  end

  assign w_accept = cipher_valid && w_cipher_ready;

  // Key load outranks accept/drain: the pending byte is dropped and the stream restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= '0;
      r_plain <= '0;
    end else if (key_load) begin
      r_lfsr      <= key_seed(key_base);
      r_plain.vld <= 1'b0;
    end else if (w_accept) begin
      r_lfsr  <= w_lfsr_nxt;
      r_plain <= '{vld: 1'b1, data: cipher_in ^ r_lfsr};
    end else if (plain_ready) begin
      r_plain.vld <= 1'b0;
    end
  end

`ifdef XSD_BYTE_COUNT_EN
  logic [7:0] r_byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_byte_cnt <= '0;
    else if (key_load) r_byte_cnt <= '0;
    else if (w_accept) r_byte_cnt <= r_byte_cnt + 8'd1;
  end

  assign byte_cnt = r_byte_cnt;
`else
  assign byte_cnt = 8'h00;
`endif

  assign cipher_ready = w_cipher_ready;
  assign plain_out    = r_plain.data;
  assign plain_valid  = r_plain.vld;
  assign key_cur      = r_lfsr;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Randomized + directed bench for xor_stream_decoder against a transaction-level model.
// Counter expectations follow XSD_BYTE_COUNT_EN the same way the build does.
module tb_xor_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_base, cipher_in;
  logic       key_load, cipher_valid, plain_ready;
  wire        cipher_ready, plain_valid;
  wire  [7:0] plain_out, key_cur, byte_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  bit       m_run;
  bit       m_pend;
  int       m_key;
  int       m_pout;
  int       m_cnt;

  always #5 clk = ~clk;

  xor_stream_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_base     (key_base),
    .key_load     (key_load),
    .cipher_in    (cipher_in),
    .cipher_valid (cipher_valid),
    .cipher_ready (cipher_ready),
    .plain_out    (plain_out),
    .plain_valid  (plain_valid),
    .plain_ready  (plain_ready),
    .key_cur      (key_cur),
    .byte_cnt     (byte_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // keystream step written arithmetically: double mod 256 plus feedback bit
  function automatic int ks_next(input int k);
    return ((k * 2) % 256) + (((k / 16) % 2) ^ ((k / 8) % 2));
  endfunction

  function automatic int exp_cnt();
`ifdef XSD_BYTE_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_key = 0; m_pout = 0; m_cnt = 0;
  endtask

  // One clock: check the combinational ready at negedge, advance model at posedge, check regs after.
  task automatic cyc();
    bit rdy, acc, drain;
    @(negedge clk);
    rdy   = m_run && !key_load && (!m_pend || plain_ready);
    acc   = rdy && cipher_valid;
    drain = m_pend && plain_ready;
    chk("cipher_ready", cipher_ready, rdy);
    @(posedge clk);
    if (key_load) begin
      m_run = 1; m_pend = 0; m_cnt = 0;
      m_key = (key_base == 8'h00) ? 1 : int'(key_base);
    end else if (acc) begin
      m_pout = int'(cipher_in) ^ m_key;
      m_key  = ks_next(m_key);
      m_pend = 1;
      m_cnt  = (m_cnt + 1) % 256;
    end else if (drain) begin
      m_pend = 0;
    end
    #1;
    chk("plain_valid", plain_valid, m_pend);
    chk("plain_out", plain_out, m_pout);
    chk("key_cur", key_cur, m_key);
    chk("byte_cnt", byte_cnt, exp_cnt());
  endtask

  task automatic drive(input bit kl, input logic [7:0] kb, input bit cv, input logic [7:0] ci,
                       input bit pr);
    key_load = kl; key_base = kb; cipher_valid = cv; cipher_in = ci; plain_ready = pr;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 0);
    #12;
    chk("rst_cipher_ready", cipher_ready, 1'b0);
    chk("rst_plain_valid", plain_valid, 1'b0);
    chk("rst_plain_out", plain_out, 8'h00);
    chk("rst_key_cur", key_cur, 8'h00);
    chk("rst_byte_cnt", byte_cnt, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE ignores input
    drive(0, 8'h00, 1, 8'hAA, 1); cyc(); cyc();

    // key 5A, then 3C -> 66, B4 -> 00 back-to-back
    drive(1, 8'h5A, 1, 8'h77, 1); cyc();
    chk("load_key_5a", key_cur, 8'h5A);
    drive(0, 8'h5A, 1, 8'h3C, 1); cyc();
    chk("dir_plain_66", plain_out, 8'h66);
    chk("dir_key_b4", key_cur, 8'hB4);
    drive(0, 8'h5A, 1, 8'hB4, 1); cyc();
    chk("dir_plain_00", plain_out, 8'h00);
    chk("dir_key_69", key_cur, 8'h69);
    chk("dir_no_bubble", plain_valid, 1'b1);

    // 3-cycle stall: nothing moves, then the held cipher byte is taken
    drive(0, 8'h5A, 1, 8'h11, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_plain_out", plain_out, 8'h00);
      chk("stall_key_cur", key_cur, 8'h69);
      chk("stall_valid", plain_valid, 1'b1);
    end
    drive(0, 8'h5A, 1, 8'h11, 1); cyc();
    chk("stall_resume_78", plain_out, 8'h78);

    // key_load with cipher_valid: byte not taken
    drive(1, 8'hC3, 1, 8'h55, 1); cyc();
    chk("kl_prio_valid", plain_valid, 1'b0);
    chk("kl_prio_key", key_cur, 8'hC3);
    chk("kl_prio_cnt", byte_cnt, 8'h00);

    // zero key substitute
    drive(1, 8'h00, 0, 8'h00, 1); cyc();
    chk("zero_key_01", key_cur, 8'h01);
    drive(0, 8'h00, 1, 8'hFF, 1); cyc();
    chk("zero_key_fe", plain_out, 8'hFE);

    // 256 accepted bytes: counter wraps
    drive(1, 8'h3D, 0, 8'h00, 1); cyc();
    for (int i = 0; i < 256; i++) begin
      drive(0, 8'h3D, 1, 8'($urandom), 1); cyc();
      if (i == 254) begin
`ifdef XSD_BYTE_COUNT_EN
        chk("cnt_ff", byte_cnt, 8'hFF);
`else
        chk("cnt_off", byte_cnt, 8'h00);
`endif
      end
    end
    chk("cnt_wrap", byte_cnt, 8'h00);

    // random traffic with a mid-stream reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
      cyc();
      if (i == 300) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("mid_rst_ready", cipher_ready, 1'b0);
        chk("mid_rst_valid", plain_valid, 1'b0);
        chk("mid_rst_key", key_cur, 8'h00);
        chk("mid_rst_cnt", byte_cnt, 8'h00);
        rst_n = 1'b1;
        drive(0, 8'h12, 1, 8'h34, 1);
        for (int j = 0; j < 4; j++) cyc();
        chk("post_rst_idle_valid", plain_valid, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
